// File: rtl/alu_serial_pkg.sv
// Shared opcode constants, FSM state encoding and a small opcode helper
// used by the serial ALU and its slice.
package alu_serial_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // SUB and SLT both compute a + ~b + 1
    function automatic logic op_inverts_b(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// Combinational SLICE-bit ALU slice: adder with optional B inversion plus
// the bitwise logic ops. Also reports the carry into the slice MSB.
module alu_slice
    import alu_serial_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic [SLICE-1:0] res,
    output logic             cout,
    output logic             cmsb
);

    logic [SLICE-1:0] bx_s;
    logic [SLICE:0]   sum_s;

    // Adder, MSB carry recovery and op select
    always_comb begin
        bx_s  = op_inverts_b(op) ? ~b : b;
        sum_s = {1'b0, a} + {1'b0, bx_s} + {{SLICE{1'b0}}, cin};
        cout  = sum_s[SLICE];
        // sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out by XOR
        cmsb  = sum_s[SLICE-1] ^ a[SLICE-1] ^ bx_s[SLICE-1];
        case (op)
            OP_ADD, OP_SUB, OP_SLT: res = sum_s[SLICE-1:0];
            OP_XOR:                 res = a ^ b;
            OP_AND:                 res = a & b;
            OP_NAND:                res = ~(a & b);
            OP_NOR:                 res = ~(a | b);
            OP_OR:                  res = a | b;
            default:                res = {SLICE{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle serial ALU: processes SLICE bits per clock, LSB slice first,
// with ready/valid handshakes and carry/overflow/zero flags.
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    state_t           state_r, state_nx_s;
    logic [WIDTH-1:0] a_sh_r, b_sh_r, result_r, shift_s, final_s;
    logic [2:0]       op_r;
    logic             cy_r, carry_r, overflow_r, zero_r;
    logic [KW-1:0]    k_r;
    logic             last_s;
    logic [SLICE-1:0] slice_res_s;
    logic             cout_s, cmsb_s;
    logic             carry_f_s, ovf_f_s, zero_f_s;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_sh_r[SLICE-1:0]),
        .b    (b_sh_r[SLICE-1:0]),
        .cin  (cy_r),
        .op   (op_r),
        .res  (slice_res_s),
        .cout (cout_s),
        .cmsb (cmsb_s)
    );

    assign last_s = (k_r == KW'(N - 1));

    // New slice enters at the top of the result register, older bits move down
    if (N > 1) begin : g_shift
        assign shift_s = {slice_res_s, result_r[WIDTH-1:SLICE]};
    end else begin : g_single
        assign shift_s = slice_res_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = in_valid  ? BUSY : IDLE;
            BUSY:    state_nx_s = last_s    ? DONE : BUSY;
            DONE:    state_nx_s = out_ready ? IDLE : DONE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Final result and flags, meaningful on the last slice only
    always_comb begin
        final_s   = shift_s;
        carry_f_s = 1'b0;
        ovf_f_s   = 1'b0;
        case (op_r)
            OP_ADD, OP_SUB: begin
                carry_f_s = cout_s;
                ovf_f_s   = cmsb_s ^ cout_s;
            end
            OP_SLT: begin
                carry_f_s = cout_s;
                final_s   = {{(WIDTH-1){1'b0}}, slice_res_s[SLICE-1] ^ cmsb_s ^ cout_s};
            end
            default: carry_f_s = 1'b0;
        endcase
        zero_f_s = (final_s == {WIDTH{1'b0}});
    end

    // Operand shifters, slice counter, carry chain and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh_r     <= {WIDTH{1'b0}};
            b_sh_r     <= {WIDTH{1'b0}};
            op_r       <= OP_ADD;
            cy_r       <= 1'b0;
            k_r        <= {KW{1'b0}};
            result_r   <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r <= a;
                        b_sh_r <= b;
                        op_r   <= op;
                        cy_r   <= op_inverts_b(op);
                        k_r    <= {KW{1'b0}};
                    end
                end
                BUSY: begin
                    a_sh_r <= a_sh_r >> SLICE;
                    b_sh_r <= b_sh_r >> SLICE;
                    cy_r   <= cout_s;
                    k_r    <= k_r + KW'(1);
                    if (last_s) begin
                        result_r   <= final_s;
                        carry_r    <= carry_f_s;
                        overflow_r <= ovf_f_s;
                        zero_r     <= zero_f_s;
                    end else begin
                        result_r   <= shift_s;
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign result   = result_r;
    assign carry    = carry_r;
    assign overflow = overflow_r;
    assign zero     = zero_r;

endmodule

// File: tb/tb_alu_serial.sv
// Randomized scoreboard bench for alu_serial (WIDTH=8, SLICE=2) against an
// arithmetic reference model.
module tb_alu_serial;

    localparam int W = 8;
    localparam int S = 2;
    localparam int N = W / S;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, in_valid, out_ready;
    logic         in_ready, out_valid, carry, overflow, zero;
    logic [W-1:0] a_i, b_i, result;
    logic [2:0]   op_i;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;

    alu_serial #(.WIDTH(W), .SLICE(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .op        (op_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        exp_t e;
        int   sa, sb, r;
        e  = '0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            3'b000: begin
                r = int'(a) + int'(b);
                e.res = r[7:0];
                e.c = (r > 255);
                e.v = (sa + sb > 127) || (sa + sb < -128);
            end
            3'b001: begin
                r = int'(a) - int'(b);
                e.res = r[7:0];
                e.c = (a >= b);
                e.v = (sa - sb > 127) || (sa - sb < -128);
            end
            3'b011: begin
                e.res = (sa < sb) ? 8'd1 : 8'd0;
                e.c = (a >= b);
            end
            3'b010:  e.res = a ^ b;
            3'b100:  e.res = a & b;
            3'b101:  e.res = ~(a & b);
            3'b110:  e.res = ~(a | b);
            default: e.res = a | b;
        endcase
        e.z = (e.res == 8'd0);
        return e;
    endfunction

    // Monitor: every consumed result is compared with the oldest expectation
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got %h want none", result);
            end else begin
                chk("result_flags", {result, carry, overflow, zero}, sb_q.pop_front());
            end
        end
    end

    task automatic scramble();
        a_i      = 8'($urandom);
        b_i      = 8'($urandom);
        op_i     = 3'($urandom);
        in_valid = 1'($urandom);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int hold);
        exp_t e;
        int   g, edges;
        g = 0;
        while (!in_ready && g < 20) begin
            @(posedge clk); #1; g++;
        end
        chk("in_ready_before_issue", in_ready, 1);
        a_i = a; b_i = b; op_i = op; in_valid = 1'b1;
        e = model(a, b, op);
        @(posedge clk); #1;
        sb_q.push_back(e);
        edges = 0;
        scramble();
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1; edges++;
            scramble();
        end
        chk("latency", edges, N);
        for (int i = 0; i < hold; i++) begin
            chk("hold_stable", {result, carry, overflow, zero}, e);
            chk("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
            scramble();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_i = 8'd0; b_i = 8'd0; op_i = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {in_ready, out_valid, result, carry, overflow, zero}, {1'b1, 1'b0, 8'h00, 3'b000});
        reset = 1'b0;

        do_op(8'hF0, 8'h20, 3'b000, 0);
        do_op(8'h80, 8'h01, 3'b001, 1);
        do_op(8'h05, 8'h05, 3'b001, 0);
        do_op(8'hFF, 8'h01, 3'b011, 0);
        do_op(8'h7F, 8'h80, 3'b011, 0);
        do_op(8'h00, 8'h00, 3'b110, 0);
        do_op(8'hFF, 8'h0F, 3'b101, 0);
        do_op(8'hA5, 8'h3C, 3'b010, 3);
        do_op(8'h7F, 8'h01, 3'b000, 0);
        do_op(8'h01, 8'h02, 3'b011, 0);

        // Abort an ADD partway through with reset
        @(posedge clk); #1;
        a_i = 8'h5A; b_i = 8'h33; op_i = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_outputs", {in_ready, out_valid, result, carry, overflow, zero}, {1'b1, 1'b0, 8'h00, 3'b000});
        do_op(8'h01, 8'h01, 3'b000, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(8'($urandom), 8'($urandom), 3'($urandom), int'($urandom_range(0, 2)));
        end

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
